// File: rtl/mac_result_fifo.sv
// mac_result_fifo: first-word-fall-through result queue behind the MAC stage.
// Upstream is never stalled. A word that arrives while the queue is full and
// no pop is happening is dropped, and the sticky overflow flag records it.
// Optional feature: define MAC_FIFO_PEAK_EN to add the 'peak' port, which
// tracks the largest word accepted since reset.
module mac_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
`ifdef MAC_FIFO_PEAK_EN
    ,
    output logic [WIDTH-1:0]           peak
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q;
    logic             overflow_q, overflow_d;
    logic             push, pop;

    // Handshake decode and next-state for pointers, occupancy and overflow.
    // A full queue still accepts a word when the head leaves in the same cycle.
    always_comb begin
        pop        = out_valid_q & out_ready;
        push       = in_valid & ((count_q != FULL) | pop);
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q | (in_valid & ~push);
    end

    // Control state; out_valid is registered from the same next count so it
    // always matches count != 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= (count_d != '0);
            overflow_q  <= overflow_d;
        end
    end

    // Storage is not reset; stale contents are hidden by out_valid gating.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;

`ifdef MAC_FIFO_PEAK_EN
    logic [WIDTH-1:0] peak_q;

    // Running maximum over accepted words only; dropped words never count.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else if (push && (in_data > peak_q)) begin
            peak_q <= in_data;
        end
    end

    assign peak = peak_q;
`endif

endmodule
